// File: rtl/nibble_add_pkg.sv
// -----------------------------------------------------------------------------
// nibble_add_pkg
// Shared definitions for the nibble-serial adder controller:
//   - state_t  : controller FSM states (IDLE, RUN, DONE)
//   - NIBBLE_W : width of the single arithmetic slice (4 bits)
//   - nib_count: number of nibbles in an operand of a given width
// -----------------------------------------------------------------------------
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Number of NIBBLE_W-wide slices in an operand of the given width.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_adder_4bit.sv
// -----------------------------------------------------------------------------
// adder_4bit
// The single 4-bit arithmetic slice used by nibble_serial_add_ctrl.
// Ports:
//   a, b  in  4  nibble operands
//   ci    in  1  carry-in
//   s     out 4  nibble sum
//   co    out 1  carry-out
// -----------------------------------------------------------------------------
import nibble_add_pkg::*;

module adder_4bit (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] total_s;

  // Widen by one bit so the carry-out falls out of the top of the sum.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
    s       = total_s[NIBBLE_W-1:0];
    co      = total_s[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
// Computes op_a + op_b + op_ci one nibble per cycle, LSB nibble first, using a
// single adder_4bit. A result appears WIDTH/4 cycles after the operands are
// accepted and is held until the consumer takes it.
//
// Optional feature: define ADD_SUB_EN to add port op_sub. When op_sub=1 at
// acceptance the block computes op_a - op_b (co=1 means no borrow).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair offered
//   in_ready   out  1      controller can accept operands (IDLE only)
//   op_a       in   WIDTH  operand A
//   op_b       in   WIDTH  operand B
//   op_ci      in   1      initial carry-in
//   op_sub     in   1      subtract request (ADD_SUB_EN builds only)
//   out_valid  out  1      result available
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result (modulo 2^WIDTH)
//   co         out  1      final carry-out
// Parameter WIDTH must be a multiple of 4 and at least 8.
// -----------------------------------------------------------------------------
import nibble_add_pkg::*;

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_ci,
`ifdef ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               co_q, co_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [WIDTH-1:0]    b_in_s;
  logic                ci_in_s;
  logic [NIBBLE_W-1:0] a_nib_s;
  logic [NIBBLE_W-1:0] b_nib_s;
  logic [NIBBLE_W-1:0] add_sum_s;
  logic                add_co_s;

  // Operand conditioning at acceptance: subtraction is A + ~B + 1.
  always_comb begin
`ifdef ADD_SUB_EN
    if (op_sub) begin
      b_in_s  = ~op_b;
      ci_in_s = 1'b1;
    end else begin
      b_in_s  = op_b;
      ci_in_s = op_ci;
    end
`else
    b_in_s  = op_b;
    ci_in_s = op_ci;
`endif
  end

  // Select the nibble pair currently being processed.
  always_comb begin
    a_nib_s = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    b_nib_s = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  end

  adder_4bit u_adder_4bit (
    .a  (a_nib_s),
    .b  (b_nib_s),
    .ci (carry_q),
    .s  (add_sum_s),
    .co (add_co_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    co_d        = co_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d         = op_a;
          b_d         = b_in_s;
          carry_d     = ci_in_s;
          idx_d       = '0;
          sum_d       = '0;
          co_d        = 1'b0;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b0;
          state_d     = RUN;
        end else begin
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end

      RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = add_sum_s;
        carry_d = add_co_s;
        if (idx_q == IDX_LAST) begin
          co_d        = add_co_s;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      DONE: begin
        // Back to IDLE only; the earliest next acceptance is a cycle later.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign co        = co_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
// Directed, self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
// Expected results are pushed to a scoreboard queue on acceptance and compared
// on each result handshake.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             drv_sub;
`ifdef ADD_SUB_EN
  logic             op_sub;
  assign op_sub = drv_sub;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
  } res_t;

  res_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_rise = -1;
  bit   chk_spacing = 1'b0;
  logic prev_ov;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_ci     (op_ci),
`ifdef ADD_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
  );

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic sub);
    logic [WIDTH:0] t;
    res_t r;
    if (sub) begin
      t   = {1'b0, a} - {1'b0, b};
      r.s = t[WIDTH-1:0];
      r.c = ~t[WIDTH];
    end else begin
      t   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      r.s = t[WIDTH-1:0];
      r.c = t[WIDTH];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes that the coming edge completes, then sample #1 after it.
  task automatic step();
    bit   acc;
    bit   hs;
    res_t e;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    if (hs) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("co", 32'(co), 32'(e.c));
      end
    end
    if (acc) begin
      sb.push_back(model(op_a, op_b, op_ci, drv_sub));
      acc_cyc = cyc + 1;
    end
    prev_ov = out_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid && !prev_ov) begin
      chk("latency", 32'(cyc - acc_cyc), 32'd4);
      if (chk_spacing && last_rise >= 0) chk("spacing", 32'(cyc - last_rise), 32'd6);
      last_rise = cyc;
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic sub);
    int n;
    op_a = a; op_b = b; op_ci = ci; drv_sub = sub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    wait_out();
    step();
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   k;
    bit   acc;
    logic [WIDTH-1:0] s0;
    logic c0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_ci = 1'b0; drv_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic adds, including a full carry ripple.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    end

    // Consumer stall with new operands offered throughout.
    op_a = 16'hABCD; op_b = 16'h1111; op_ci = 1'b1; drv_sub = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_out();
    s0 = sum; c0 = co;
    op_a = 16'h0F0F; op_b = 16'h7070; op_ci = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(s0));
      chk("stall_co", 32'(co), 32'(c0));
    end
    out_ready = 1'b1;
    step();
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    wait_out();
    step();
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during the second RUN cycle.
    op_a = 16'h9999; op_b = 16'h6666; op_ci = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_co", 32'(co), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_result_after_rst", 32'(out_valid), 32'd0);
    end
    do_op(16'h0FF0, 16'h0011, 1'b0, 1'b0);

    // Back-to-back operands with the consumer always ready.
    chk_spacing = 1'b1;
    last_rise = -1;
    k = 0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); op_ci = 1'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 60 && k < 4; i++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        k++;
        op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); op_ci = 1'($urandom);
        if (k == 4) in_valid = 1'b0;
      end
    end
    chk("b2b_accepts", 32'(k), 32'd4);
    wait_out();
    step();
    chk_spacing = 1'b0;
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

`ifdef ADD_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    do_op(16'h1234, 16'h1234, 1'b0, 1'b1);
    drv_sub = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Ports (clock and reset first):
  clk        in   1      sole clock, rising edge
  rst_n      in   1      asynchronous, active-low reset
  in_valid   in   1      operand pair offered
  in_ready   out  1      controller can accept operands
  op_a       in   WIDTH  operand A
  op_b       in   WIDTH  operand B
  op_ci      in   1      initial carry-in
  op_sub     in   1      subtract request; present only with ADD_SUB_EN
  out_valid  out  1      result available
  out_ready  in   1      consumer accepts result
  sum        out  WIDTH  result
  co         out  1      final carry-out
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL compute op_a + op_b + op_ci using a single 4-bit adder, one nibble per cycle, LSB nibble first.
REQ-005 FSM states SHALL be IDLE, RUN and DONE.
REQ-006 IDLE: in_ready=1; when in_valid&&in_ready, the block SHALL latch op_a, op_b and the carry, clear the nibble index to 0, and go to RUN.
REQ-007 RUN: each cycle the block SHALL add nibble[idx] of A and B with the carry register, write the 4-bit sum into sum[4*idx+3:4*idx], load the adder carry-out into the carry register, and increment idx.
REQ-008 When the last nibble (idx=WIDTH/4-1) is processed, the block SHALL go to DONE; co SHALL equal the final carry-out.
REQ-009 Latency SHALL be WIDTH/4 cycles from the accepting edge to out_valid=1 (4 cycles at WIDTH=16).
REQ-010 DONE: out_valid=1; sum and co SHALL stay stable until out_valid&&out_ready, then go to IDLE.
REQ-011 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored there, and operands offered then SHALL NOT be latched.
REQ-012 A new operation SHALL NOT be accepted in the same cycle the result handshake completes; the minimum issue interval SHALL be WIDTH/4+2 cycles.
REQ-013 Sum SHALL wrap modulo 2^WIDTH; overflow out of the MSB SHALL be reported only through co.
REQ-014 out_ready held at 0 SHALL hold the block in DONE indefinitely with no change to sum or co.

Reset
REQ-015 While rst_n=0, state SHALL be IDLE, idx=0, the carry register=0, sum=0, co=0, out_valid=0 and in_ready=1.
REQ-016 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no result SHALL be presented after reset release.

Configuration
REQ-017 Macro ADD_SUB_EN: when defined, port op_sub SHALL exist; if op_sub=1 at acceptance, the block SHALL latch ~op_b and force the initial carry to 1, ignoring op_ci, so that sum=op_a-op_b and co=1 means no borrow.
REQ-018 Without ADD_SUB_EN, port op_sub SHALL be absent and the block SHALL only add.

Structure
REQ-019 Shared package nibble_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
REQ-020 The block SHALL instantiate exactly one adder_4bit as its arithmetic sub-module; no other adder logic SHALL exist.

Verification
REQ-021 WIDTH=16, A=0x1234, B=0x4321, ci=0 -> out_valid exactly 4 cycles after acceptance; sum=0x5555, co=0.
REQ-022 A=0xFFFF, B=0x0000, ci=1 -> carry ripples through all nibbles; sum=0x0000, co=1.
REQ-023 out_ready held 0 for 10 cycles in DONE while in_valid=1 with new operands -> in_ready=0 throughout, sum/co unchanged, second operation accepted only after the handshake completes and the block is back in IDLE.
REQ-024 rst_n pulsed low during the 2nd RUN cycle -> all outputs go to reset values immediately; out_valid never rises for the aborted operation; the next operation completes correctly.
REQ-025 With ADD_SUB_EN: A=0x0005, B=0x0007, op_sub=1 -> sum=0xFFFE, co=0; A=0x0007, B=0x0005, op_sub=1 -> sum=0x0002, co=1.
REQ-026 Back-to-back in_valid=1 with out_ready=1 -> results spaced 6 cycles apart at WIDTH=16, all sums correct.
